// File: rtl/mem_block_ctrl.sv
// Miss handler for a blocking cache: optional victim writeback, then a block fill
// from a banked word-addressed backing store, each taking LATENCY cycles.
module mem_block_ctrl #(
    parameter int RAM_SIZE    = 65536,
    parameter int BLOCK_WORDS = 2,
    parameter int LATENCY     = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       mem_req,
    input  logic                       mem_we,
    input  logic [31:0]                mem_addr,
    input  logic [31:0]                mem_wb_addr,
    input  logic [BLOCK_WORDS*32-1:0]  mem_wb_data,
    output logic                       mem_miss,
    output logic [BLOCK_WORDS*32-1:0]  mem_req_blk,
    output logic                       busy
);

    localparam int IDX_W = $clog2(RAM_SIZE);
    localparam int OFF_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 0;
    localparam int ROW_W = IDX_W - OFF_W;
    localparam int ROWS  = RAM_SIZE / BLOCK_WORDS;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WB, FILL, RESP} state_t;

    state_t                      state_reg, state_next;
    logic [CNT_W-1:0]            cnt_reg, cnt_next;
    logic [ROW_W-1:0]            fill_row_reg, fill_row_next;
    logic [ROW_W-1:0]            wb_row_reg, wb_row_next;
    logic [BLOCK_WORDS*32-1:0]   wb_data_reg, wb_data_next;
    logic                        miss_reg, miss_next;
    logic                        busy_reg;
    logic                        wr_en, rd_en;
    logic                        unused_addr_bits;

    // Byte offset, block offset and bits above the store depth are dropped by
    // taking only the row field, which gives modulo-RAM_SIZE wrap for free.
    assign unused_addr_bits = ^{mem_addr, mem_wb_addr};

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        fill_row_next = fill_row_reg;
        wb_row_next   = wb_row_reg;
        wb_data_next  = wb_data_reg;
        miss_next     = 1'b1;
        wr_en         = 1'b0;
        rd_en         = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (mem_req) begin
                    fill_row_next = mem_addr[2+OFF_W +: ROW_W];
                    wb_row_next   = mem_wb_addr[2+OFF_W +: ROW_W];
                    wb_data_next  = mem_wb_data;
                    cnt_next      = CNT_LOAD;
                    state_next    = mem_we ? WB : FILL;
                end
            end
            WB: begin
                if (cnt_reg == '0) begin
                    // Writeback always completes, even if the requester gave up.
                    wr_en      = 1'b1;
                    cnt_next   = mem_req ? CNT_LOAD : '0;
                    state_next = mem_req ? FILL : IDLE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            FILL: begin
                if (!mem_req) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end else if (cnt_reg == '0) begin
                    rd_en      = 1'b1;
                    miss_next  = 1'b0;
                    state_next = RESP;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            miss_reg  <= 1'b1;
            busy_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            miss_reg     <= miss_next;
            busy_reg     <= (state_next != IDLE);
            fill_row_reg <= fill_row_next;
            wb_row_reg   <= wb_row_next;
            wb_data_reg  <= wb_data_next;
        end
    end

    assign mem_miss = miss_reg;
    assign busy     = busy_reg;

    // One bank per block word so a whole block is written or read in one edge.
    genvar gi;
    generate
        for (gi = 0; gi < BLOCK_WORDS; gi++) begin : g_bank
            logic [31:0] ram [ROWS];
            logic [31:0] rd_data_reg;

            always_ff @(posedge clock) begin
                if (wr_en && !reset) begin
                    ram[wb_row_reg] <= wb_data_reg[gi*32 +: 32];
                end
            end

            always_ff @(posedge clock) begin
                if (reset) begin
                    rd_data_reg <= '0;
                end else if (rd_en) begin
                    rd_data_reg <= ram[fill_row_reg];
                end
            end

            assign mem_req_blk[gi*32 +: 32] = rd_data_reg;
        end
    endgenerate

endmodule

// File: tb/tb_mem_block_ctrl.sv
// Scoreboard bench for mem_block_ctrl: expected fill blocks and response cycles
// are queued at request time and checked whenever mem_miss drops.
module tb_mem_block_ctrl;

    localparam int L = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wb_addr = '0;
    logic [63:0] mem_wb_data = '0;
    logic        mem_miss;
    logic [63:0] mem_req_blk;
    logic        busy;

    mem_block_ctrl #(.RAM_SIZE(65536), .BLOCK_WORDS(2), .LATENCY(L)) dut (
        .clock       (clock),
        .reset       (reset),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wb_addr (mem_wb_addr),
        .mem_wb_data (mem_wb_data),
        .mem_miss    (mem_miss),
        .mem_req_blk (mem_req_blk),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [63:0] data;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model [int];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    function automatic int blk_base(input logic [31:0] addr);
        return int'((addr >> 2) & 32'h0000_FFFE);
    endfunction

    function automatic logic [63:0] model_blk(input logic [31:0] addr);
        int b;
        b = blk_base(addr);
        return {model[b+1], model[b]};
    endfunction

    // Called at a negedge; the DUT samples the request at the edge 'delay' later.
    task automatic start(input logic we, input logic [31:0] addr, input logic [31:0] wb_addr,
                         input logic [63:0] wb_data, input bit expect_resp, input int delay);
        int b;
        mem_we      = we;
        mem_addr    = addr;
        mem_wb_addr = wb_addr;
        mem_wb_data = wb_data;
        mem_req     = 1'b1;
        if (we) begin
            b = blk_base(wb_addr);
            model[b]   = wb_data[31:0];
            model[b+1] = wb_data[63:32];
        end
        if (expect_resp)
            exp_q.push_back('{data: model_blk(addr), cyc: cyc + delay + (we ? 2 : 1) * L});
    endtask

    task automatic wait_resp(input bit hold);
        bit seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (!mem_miss) begin
                seen = 1'b1;
                break;
            end
        end
        check("resp_timeout", {63'd0, seen}, 64'd1);
        if (!hold) mem_req = 1'b0;
    endtask

    always @(negedge clock) begin
        if (!reset && !mem_miss) begin
            check("resp_expected", {63'd0, exp_q.size() > 0}, 64'd1);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("fill_data", mem_req_blk, e.data);
                check("fill_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    initial begin
        repeat (3) @(negedge clock);
        check("rst_miss", {63'd0, mem_miss}, 64'd1);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_blk", mem_req_blk, 64'd0);
        reset = 1'b0;
        @(negedge clock);

        // Seed block 0x10 via a same-block writeback+fill, then a clean fill.
        start(1'b1, 32'h40, 32'h40, 64'hA5A50002_A5A50001, 1'b1, 1);
        @(negedge clock);
        check("busy_in_wb", {63'd0, busy}, 64'd1);
        wait_resp(1'b0);
        @(negedge clock);
        start(1'b0, 32'h40, 32'h0, 64'h0, 1'b1, 1);
        wait_resp(1'b0);
        @(negedge clock);
        check("blk_hold", mem_req_blk, 64'hA5A50002_A5A50001);
        check("miss_after_resp", {63'd0, mem_miss}, 64'd1);

        // Dirty fill: victim to 0x80, fill 0x40; then read the victim back.
        start(1'b1, 32'h40, 32'h80, 64'h22222222_11111111, 1'b1, 1);
        wait_resp(1'b0);
        @(negedge clock);
        start(1'b0, 32'h80, 32'h0, 64'h0, 1'b1, 1);
        wait_resp(1'b0);
        @(negedge clock);

        // Same block, unaligned address.
        start(1'b1, 32'h44, 32'h44, 64'hBEEF0001_CAFE0000, 1'b1, 1);
        wait_resp(1'b0);
        @(negedge clock);

        // Wrap: write word 0/1, read via 0x4_0000; write via 0x4_0008, read 0x8.
        start(1'b1, 32'h0, 32'h0, 64'h00000B0B_00000A0A, 1'b1, 1);
        wait_resp(1'b0);
        @(negedge clock);
        start(1'b0, 32'h0004_0000, 32'h0, 64'h0, 1'b1, 1);
        wait_resp(1'b0);
        @(negedge clock);
        start(1'b1, 32'h8, 32'h0004_0008, 64'h0000D0D0_0000C0C0, 1'b1, 1);
        wait_resp(1'b0);
        @(negedge clock);

        // Abort two cycles into FILL: no response, back to IDLE next edge.
        start(1'b0, 32'h80, 32'h0, 64'h0, 1'b0, 1);
        repeat (3) @(negedge clock);
        mem_req = 1'b0;
        @(negedge clock);
        check("fill_abort_busy", {63'd0, busy}, 64'd0);
        repeat (6) @(negedge clock);

        // Drop during WB: writeback still lands, no response.
        start(1'b1, 32'h40, 32'hC0, 64'h44444444_33333333, 1'b0, 1);
        @(negedge clock);
        mem_req = 1'b0;
        repeat (8) @(negedge clock);
        check("wb_abort_busy", {63'd0, busy}, 64'd0);
        start(1'b0, 32'hC0, 32'h0, 64'h0, 1'b1, 1);
        wait_resp(1'b0);
        @(negedge clock);

        // Reset at E0+2 during WB, with mem_req still high at that edge.
        mem_we      = 1'b1;
        mem_wb_addr = 32'h80;
        mem_wb_data = 64'hDEADDEAD_DEADDEAD;
        mem_addr    = 32'h40;
        mem_req     = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("wb_rst_busy", {63'd0, busy}, 64'd0);
        check("wb_rst_miss", {63'd0, mem_miss}, 64'd1);
        check("wb_rst_blk", mem_req_blk, 64'd0);
        reset   = 1'b0;
        mem_req = 1'b0;
        @(negedge clock);
        start(1'b0, 32'h80, 32'h0, 64'h0, 1'b1, 1);
        wait_resp(1'b1);
        // Back-to-back: keep mem_req high through RESP; IDLE picks it up next.
        start(1'b0, 32'h40, 32'h0, 64'h0, 1'b1, 2);
        wait_resp(1'b0);
        repeat (4) @(negedge clock);

        check("pending_resp", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_block_ctrl.md
MEM_BLOCK_CTRL -- requirements
Module: mem_block_ctrl

Interface
REQ-001 SHALL have parameter RAM_SIZE, 65536, backing store depth in 32-bit words (power of two).
REQ-002 SHALL have parameter BLOCK_WORDS, 2, words per cache block (power of two, >=1).
REQ-003 SHALL have parameter LATENCY, 4, cycles per RAM block access (>=1).
REQ-004 SHALL have port clock  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port mem_req  in  1  cache miss request, held high until serviced.
REQ-007 SHALL have port mem_we  in  1  victim writeback required with this request.
REQ-008 SHALL have port mem_addr  in  32  byte address of block to fill.
REQ-009 SHALL have port mem_wb_addr  in  32  byte address of victim block.
REQ-010 SHALL have port mem_wb_data  in  BLOCK_WORDS*32  victim data, word 0 in LSBs.
REQ-011 SHALL have port mem_miss  out  1  high = fill data not yet available.
REQ-012 SHALL have port mem_req_blk  out  BLOCK_WORDS*32  fill data, word 0 in LSBs.
REQ-013 SHALL have port busy  out  1  high whenever state != IDLE.

Function
REQ-014 SHALL hold a RAM_SIZE x 32 word array; word index = addr[31:2] modulo RAM_SIZE (wrap, no error).
REQ-015 SHALL block-align both addresses by clearing the low log2(BLOCK_WORDS) bits of the word index; block word i at base+i.
REQ-016 SHALL implement FSM states IDLE, WB, FILL, RESP; all outputs registered.
REQ-017 IDLE: mem_req=1 at edge E0 SHALL latch mem_addr, mem_wb_addr, mem_wb_data, mem_we; go to WB if mem_we=1, else FILL; load down-counter with LATENCY-1.
REQ-018 WB: counter decrements each cycle; at counter==0 the edge SHALL write all BLOCK_WORDS latched words to RAM, reload counter, go to FILL.
REQ-019 FILL: counter decrements each cycle; at counter==0 the edge SHALL load mem_req_blk from RAM at latched fill address, clear mem_miss, go to RESP.
REQ-020 RESP: lasts exactly one cycle; next edge SHALL set mem_miss=1 and return to IDLE regardless of mem_req.
REQ-021 mem_miss SHALL be low only in RESP; clean fill low-cycle starts at E0+LATENCY, dirty at E0+2*LATENCY.
REQ-022 mem_req_blk SHALL hold its last loaded value outside RESP.
REQ-023 Inputs other than mem_req SHALL be ignored outside IDLE (latched copies used).
REQ-024 mem_req dropped during WB: writeback SHALL still complete, then return to IDLE without FILL/RESP.
REQ-025 mem_req dropped during FILL: SHALL abort to IDLE next edge, mem_miss stays 1, RAM unchanged.
REQ-026 Victim and fill addresses in same block: SHALL return the just-written data (WB precedes FILL).
REQ-027 mem_req high in IDLE the cycle after RESP SHALL start a new transaction (no dead cycle beyond IDLE).

Reset
REQ-028 reset=1 at an edge SHALL force IDLE, counter=0, mem_miss=1, mem_req_blk=0, busy=0, from any state.
REQ-029 reset mid-WB SHALL abort without RAM write; RAM contents SHALL NOT be cleared by reset.
REQ-030 reset SHALL override mem_req at the same edge.

Verification
REQ-031 Clean fill: RAM[0x10]=0xA5A5_0001, RAM[0x11]=0xA5A5_0002; mem_req=1, mem_we=0, mem_addr=0x40 at E0 -> mem_miss=0 one cycle from E0+4, mem_req_blk=0xA5A50002_A5A50001.
REQ-032 Dirty fill: mem_we=1, mem_wb_addr=0x80, mem_wb_data=0x22222222_11111111, mem_addr=0x40 -> RAM[0x20]=0x11111111, RAM[0x21]=0x22222222; mem_miss low from E0+8.
REQ-033 Same-block: mem_wb_addr=mem_addr=0x44, data 0xBEEF0001_CAFE0000 -> mem_req_blk=0xBEEF0001_CAFE0000 (aligned to 0x40).
REQ-034 Wrap: mem_addr=0x0004_0000 with RAM_SIZE=65536 -> returns RAM[0],RAM[1].
REQ-035 Abort: drop mem_req 2 cycles into FILL -> IDLE next edge, mem_miss never low; drop during WB -> RAM written, no RESP.
REQ-036 Reset mid-WB at E0+2 -> IDLE, mem_miss=1, mem_req_blk=0, victim block in RAM unchanged.
